// File: rtl/bp_fe_mock_fetch_gen.sv
// Mock front end: turns FE commands into a deterministic stream of FE-queue fetch messages,
// injecting an icache miss every miss_period_p fetches. Optional checks: BP_FE_MOCK_FETCH_CHECK_EN.
module bp_fe_mock_fetch_gen #(
    parameter int          vaddr_width_p     = 39,
    parameter int          instr_width_p     = 32,
    parameter int          miss_period_p     = 8,
    parameter logic [31:0] instr_seed_p      = 32'h0000_0013,
    localparam int         fe_cmd_width_lp   = 3 + vaddr_width_p,
    localparam int         fe_queue_width_lp = 3 + vaddr_width_p + instr_width_p
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [fe_cmd_width_lp-1:0]   fe_cmd_i,
    input  logic                         fe_cmd_v_i,
    output logic                         fe_cmd_yumi_o,
    output logic [fe_queue_width_lp-1:0] fe_queue_o,
    output logic                         fe_queue_v_o,
    input  logic                         fe_queue_ready_i,
    output logic                         error_o
);

    localparam logic [2:0] e_op_state_reset          = 3'd0;
    localparam logic [2:0] e_op_pc_redirection       = 3'd1;
    localparam logic [2:0] e_op_icache_fill_response = 3'd2;

    localparam logic       e_fe_fetch     = 1'b0;
    localparam logic       e_fe_exception = 1'b1;
    localparam logic [1:0] e_icache_miss  = 2'd1;

    localparam int cnt_w_lp = (miss_period_p > 0) ? $clog2(miss_period_p + 1) : 1;

    typedef struct packed {
        logic [2:0]               opcode;
        logic [vaddr_width_p-1:0] vaddr;
    } bp_fe_cmd_s;

    typedef struct packed {
        logic                     msg_type;
        logic [1:0]               exception_code;
        logic [vaddr_width_p-1:0] vaddr;
        logic [instr_width_p-1:0] instr;
    } bp_fe_queue_s;

    typedef enum logic [1:0] {e_wait_reset, e_fetch, e_miss_wait} state_e;

    bp_fe_cmd_s               cmd;
    bp_fe_queue_s             msg;
    state_e                   state_q, state_d;
    logic [vaddr_width_p-1:0] pc_q, pc_d;
    logic [cnt_w_lp-1:0]      miss_cnt_q, miss_cnt_d;
    logic                     miss_now;

    assign cmd          = fe_cmd_i;
    assign miss_now     = (miss_period_p != 0) && (miss_cnt_q == cnt_w_lp'(miss_period_p));
    assign fe_queue_v_o = (state_q == e_fetch);
    assign fe_cmd_yumi_o = fe_cmd_v_i & ~reset_i;

    always_comb begin
        msg = '0;
        msg.vaddr = pc_q;
        if (miss_now) begin
            msg.msg_type       = e_fe_exception;
            msg.exception_code = e_icache_miss;
        end else begin
            msg.msg_type = e_fe_fetch;
            msg.instr    = pc_q[instr_width_p-1:0] ^ instr_width_p'(instr_seed_p);
        end
    end
    assign fe_queue_o = msg;

    // A consumed command always overrides the advance caused by a same-cycle transfer.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == e_wait_reset) begin
            if (fe_cmd_v_i && cmd.opcode == e_op_state_reset) begin
                pc_d       = cmd.vaddr;
                miss_cnt_d = '0;
                state_d    = e_fetch;
            end
        end else if (fe_cmd_v_i) begin
            case (cmd.opcode)
                e_op_state_reset: begin
                    pc_d       = cmd.vaddr;
                    miss_cnt_d = '0;
                    state_d    = e_fetch;
                end
                e_op_pc_redirection: begin
                    pc_d    = cmd.vaddr;
                    state_d = e_fetch;
                end
                e_op_icache_fill_response: begin
                    if (state_q == e_miss_wait) begin
                        pc_d    = cmd.vaddr;
                        state_d = e_fetch;
                    end
                end
                default: ;
            endcase
        end else if (state_q == e_fetch && fe_queue_ready_i) begin
            if (miss_now) begin
                miss_cnt_d = '0;
                state_d    = e_miss_wait;
            end else begin
                pc_d       = pc_q + vaddr_width_p'(4);
                miss_cnt_d = miss_cnt_q + cnt_w_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_wait_reset;
            pc_q       <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

`ifdef BP_FE_MOCK_FETCH_CHECK_EN
    logic [vaddr_width_p-1:0] miss_pc_q;
    logic                     err_q, err_set;

    always_comb begin
        err_set = 1'b0;
        if (state_q != e_wait_reset && fe_cmd_v_i) begin
            if (cmd.opcode == e_op_icache_fill_response)
                err_set = (state_q != e_miss_wait) || (cmd.vaddr != miss_pc_q);
            else if (cmd.opcode != e_op_state_reset && cmd.opcode != e_op_pc_redirection)
                err_set = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            miss_pc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == e_fetch && !fe_cmd_v_i && fe_queue_ready_i && miss_now)
                miss_pc_q <= pc_q;
            if (err_set) begin
                err_q <= 1'b1;
                $error("bp_fe_mock_fetch_gen: bad command opcode=%0d vaddr=%0h", cmd.opcode, cmd.vaddr);
            end
        end
    end
    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_fe_mock_fetch_gen.sv
// Bench for bp_fe_mock_fetch_gen: hand vector table, corner sequences, then random
// traffic checked against a cycle-level behavioural model of the mock front end.
module tb_bp_fe_mock_fetch_gen;
    localparam int VW = 39;
    localparam int IW = 32;
    localparam int MP = 2;
    localparam int QW = 3 + VW + IW;
    localparam logic [2:0] OP_SR = 3'd0, OP_RD = 3'd1, OP_FILL = 3'd2, OP_BAD = 3'd3;
    localparam longint unsigned VMASK = (64'd1 << VW) - 1;
    localparam logic [VW-1:0] B = 39'h80000000;

    logic          clk = 1'b0;
    logic          rst;
    logic [VW+2:0] fe_cmd;
    logic          cmd_v, yumi, qv, rdy, err;
    logic [QW-1:0] q;

    always #5 clk = ~clk;

    bp_fe_mock_fetch_gen #(.vaddr_width_p(VW), .instr_width_p(IW), .miss_period_p(MP),
                           .instr_seed_p(32'h0000_0013)) dut (
        .clk_i(clk), .reset_i(rst), .fe_cmd_i(fe_cmd), .fe_cmd_v_i(cmd_v),
        .fe_cmd_yumi_o(yumi), .fe_queue_o(q), .fe_queue_v_o(qv),
        .fe_queue_ready_i(rdy), .error_o(err));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: mode 0=waiting for reset cmd, 1=fetching, 2=waiting for fill.
    int              m_mode, m_n;
    longint unsigned m_pc, m_misspc;
    bit              m_err;

    task automatic m_reset();
        m_mode = 0; m_n = 0; m_pc = 0; m_misspc = 0; m_err = 0;
    endtask

    function automatic logic [QW-1:0] mk_msg(input bit ex, input longint unsigned pc);
        logic [VW-1:0] va;
        logic [31:0]   lo;
        va = pc[VW-1:0];
        lo = pc[31:0];
        return ex ? {1'b1, 2'd1, va, 32'h0} : {1'b0, 2'd0, va, lo ^ 32'h13};
    endfunction

    function automatic logic [QW-1:0] m_msg();
        return mk_msg(m_n == MP, m_pc);
    endfunction

    task automatic m_step(input bit cv, input logic [2:0] op, input longint unsigned va, input bit r);
        if (m_mode == 0) begin
            if (cv && op == OP_SR) begin m_pc = va; m_n = 0; m_mode = 1; end
        end else if (cv) begin
            if (op == OP_SR) begin m_pc = va; m_n = 0; m_mode = 1; end
            else if (op == OP_RD) begin m_pc = va; m_mode = 1; end
            else if (op == OP_FILL && m_mode == 2) begin
`ifdef BP_FE_MOCK_FETCH_CHECK_EN
                if (va != m_misspc) m_err = 1;
`endif
                m_pc = va; m_mode = 1;
            end else begin
`ifdef BP_FE_MOCK_FETCH_CHECK_EN
                m_err = 1;
`endif
            end
        end else if (m_mode == 1 && r) begin
            if (m_n == MP) begin m_mode = 2; m_n = 0; m_misspc = m_pc; end
            else begin m_pc = (m_pc + 4) & VMASK; m_n++; end
        end
    endtask

    task automatic drive(input bit cv, input logic [2:0] op, input longint unsigned va, input bit r);
        logic [VW-1:0] v;
        v = va[VW-1:0];
        @(posedge clk); #1;
        cmd_v = cv; fe_cmd = {op, v}; rdy = r;
        @(negedge clk);
    endtask

    task automatic cyc(input bit cv, input logic [2:0] op, input longint unsigned va, input bit r,
                       input string tag);
        drive(cv, op, va, r);
        chk({tag, ".yumi"}, yumi, cv);
        chk({tag, ".v"}, qv, m_mode == 1);
        if (m_mode == 1) chk({tag, ".msg"}, q, m_msg());
        chk({tag, ".err"}, err, m_err);
        m_step(cv, op, va, r);
    endtask

    typedef struct {
        bit cv; logic [2:0] op; logic [VW-1:0] va; bit r;
        bit ev; bit ex; logic [VW-1:0] epc;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with a valid command present during reset.
        rst = 1'b1; cmd_v = 1'b0; rdy = 1'b0; fe_cmd = '0;
        m_reset();
        #2 cmd_v = 1'b1;
        #1;
        chk("reset.v", qv, 1'b0);
        chk("reset.yumi", yumi, 1'b0);
        chk("reset.err", err, 1'b0);
        cmd_v = 1'b0;
        @(negedge clk); rst = 1'b0;

        tbl = '{
            '{1, OP_SR,   B,             1, 0, 0, '0},
            '{0, OP_SR,   '0,            1, 1, 0, B},
            '{0, OP_SR,   '0,            1, 1, 0, B + 4},
            '{0, OP_SR,   '0,            1, 1, 1, B + 8},
            '{0, OP_SR,   '0,            1, 0, 0, '0},
            '{1, OP_FILL, B + 8,         1, 0, 0, '0},
            '{0, OP_SR,   '0,            1, 1, 0, B + 8},
            '{0, OP_SR,   '0,            0, 1, 0, B + 12},
            '{0, OP_SR,   '0,            1, 1, 0, B + 12},
            '{1, OP_RD,   B + 39'h1000,  1, 1, 1, B + 16},
            '{0, OP_SR,   '0,            1, 1, 1, B + 39'h1000},
            '{1, OP_FILL, B + 39'h1000,  1, 0, 0, '0},
            '{1, OP_RD,   B + 39'h2000,  1, 1, 0, B + 39'h1000},
            '{0, OP_SR,   '0,            1, 1, 0, B + 39'h2000},
            '{0, OP_SR,   '0,            1, 1, 0, B + 39'h2004},
            '{0, OP_SR,   '0,            0, 1, 1, B + 39'h2008},
            '{0, OP_SR,   '0,            1, 1, 1, B + 39'h2008},
            '{0, OP_SR,   '0,            1, 0, 0, '0}
        };
        foreach (tbl[i]) begin
            drive(tbl[i].cv, tbl[i].op, tbl[i].va, tbl[i].r);
            chk($sformatf("vec%0d.v", i), qv, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("vec%0d.msg", i), q, mk_msg(tbl[i].ex, tbl[i].epc));
            m_step(tbl[i].cv, tbl[i].op, tbl[i].va, tbl[i].r);
        end

        // Resume, then stall 5 cycles mid-stream and resume.
        cyc(1, OP_FILL, B + 39'h2008, 1, "fill");
        cyc(0, OP_SR, 0, 1, "run0");
        for (int i = 0; i < 5; i++) cyc(0, OP_SR, 0, 0, "stall");
        for (int i = 0; i < 3; i++) cyc(0, OP_SR, 0, 1, "resume");

        // PC wrap at the top of the virtual address space.
        cyc(1, OP_SR, VMASK & ~64'd3, 1, "wrap.sr");
        cyc(0, OP_SR, 0, 1, "wrap0");
        drive(0, OP_SR, 0, 1);
        chk("wrap.pc0", q, mk_msg(0, 0));
        m_step(0, OP_SR, 0, 1);
        cyc(0, OP_SR, 0, 1, "wrap2");

`ifdef BP_FE_MOCK_FETCH_CHECK_EN
        // Fill response with the wrong address: sticky error.
        cyc(1, OP_SR, B, 1, "e.sr");
        for (int i = 0; i < 4; i++) cyc(0, OP_SR, 0, 1, "e.run");
        cyc(1, OP_FILL, B + 12, 1, "e.fill");
        for (int i = 0; i < 3; i++) cyc(0, OP_SR, 0, 1, "e.sticky");
`endif

        // Asynchronous reset pulse mid-stream.
        cyc(1, OP_SR, B, 1, "mr.sr");
        cyc(0, OP_SR, 0, 1, "mr.run");
        @(posedge clk); #1;
        cmd_v = 1'b1; fe_cmd = {OP_RD, B}; rdy = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("midrst.v", qv, 1'b0);
        chk("midrst.yumi", yumi, 1'b0);
        chk("midrst.err", err, 1'b0);
        m_reset();
        @(negedge clk); rst = 1'b0; cmd_v = 1'b0;
        cyc(0, OP_SR, 0, 1, "postrst");

        // Randomised traffic against the model.
        cyc(1, OP_SR, B, 1, "rnd.sr");
        for (int i = 0; i < 600; i++) begin
            bit cv, r;
            logic [2:0] op;
            longint unsigned va;
            r  = ($urandom_range(0, 3) != 0);
            va = ({32'h0, $urandom} | (longint'($urandom_range(0, 127)) << 32)) & VMASK & ~64'd3;
            if (m_mode == 2) begin
                cv = ($urandom_range(0, 2) == 0);
                op = ($urandom_range(0, 3) == 0) ? OP_RD : OP_FILL;
                if (op == OP_FILL) va = m_misspc;
            end else begin
                cv = ($urandom_range(0, 7) == 0);
                op = ($urandom_range(0, 3) == 0) ? OP_SR : OP_RD;
`ifndef BP_FE_MOCK_FETCH_CHECK_EN
                if ($urandom_range(0, 5) == 0) op = ($urandom_range(0, 1) != 0) ? OP_FILL : OP_BAD;
`endif
            end
            cyc(cv, op, va, r, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
